attr_interpolator: RTL



---
 rtl/interp_pkg.sv | 22 ++
 rtl/attr_interpolator_if.sv | 46 ++++
 rtl/interp_seq_divider.sv | 81 ++++++++
 rtl/attr_interpolator.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/interp_pkg.sv
// Shared types and helpers for the attribute interpolator: FSM state encoding,
// per-channel clamp codes and the weight-width rule.
package interp_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WEIGHTS = 3'd1,
      ACCUM   = 3'd2,
      DIVIDE  = 3'd3,
      OUTPUT  = 3'd4
   } state_t;

   localparam logic [1:0] CLAMP_NONE = 2'd0;
   localparam logic [1:0] CLAMP_ZERO = 2'd1;
   localparam logic [1:0] CLAMP_SAT  = 2'd2;

   // Signed width that holds an edge-function weight and the twice-area denom.
   function automatic int unsigned wgt_width(input int unsigned coord_w);
      return 2 * coord_w + 3;
   endfunction

endpackage

// File: rtl/attr_interpolator_if.sv
// Fragment-in / result-out bus of the attribute interpolator.
// slave is the interpolator's view, master is the producer/consumer view.
interface attr_interpolator_if
   import interp_pkg::*;
#(
   parameter int unsigned COORD_W  = 10,
   parameter int unsigned ATTR_W   = 16,
   parameter int unsigned NUM_ATTR = 4
);
   localparam int unsigned WGT_W = wgt_width(COORD_W);
   localparam int unsigned VEC_W = NUM_ATTR * ATTR_W;

   logic                      in_valid;
   logic                      in_ready;
   logic [COORD_W-1:0]        frag_x;
   logic [COORD_W-1:0]        frag_y;
   logic [COORD_W-1:0]        x0;
   logic [COORD_W-1:0]        y0;
   logic [COORD_W-1:0]        x1;
   logic [COORD_W-1:0]        y1;
   logic [COORD_W-1:0]        x2;
   logic [COORD_W-1:0]        y2;
   logic [VEC_W-1:0]          attr0;
   logic [VEC_W-1:0]          attr1;
   logic [VEC_W-1:0]          attr2;
   logic signed [WGT_W-1:0]   denom;
   logic                      out_valid;
   logic                      out_ready;
   logic [COORD_W-1:0]        out_frag_x;
   logic [COORD_W-1:0]        out_frag_y;
   logic [VEC_W-1:0]          out_attr;
   logic                      out_degenerate;

   modport master (
      output in_valid, frag_x, frag_y, x0, y0, x1, y1, x2, y2,
             attr0, attr1, attr2, denom, out_ready,
      input  in_ready, out_valid, out_frag_x, out_frag_y, out_attr, out_degenerate
   );

   modport slave (
      input  in_valid, frag_x, frag_y, x0, y0, x1, y1, x2, y2,
             attr0, attr1, attr2, denom, out_ready,
      output in_ready, out_valid, out_frag_x, out_frag_y, out_attr, out_degenerate
   );

endinterface

// File: rtl/interp_seq_divider.sv
// Restoring unsigned divider: QUO_W-bit quotient in QUO_W cycles, the first
// step taken on the start edge. Requires dividend >> QUO_W < divisor.
module interp_seq_divider #(
   parameter int unsigned QUO_W = 16,
   parameter int unsigned DEN_W = 22
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [QUO_W+DEN_W-1:0]   dividend,
   input  logic [DEN_W-1:0]         divisor,
   output logic                     busy,
   output logic                     done,
   output logic [QUO_W-1:0]         quotient
);
   localparam int unsigned DVD_W = QUO_W + DEN_W;
   localparam int unsigned CNT_W = $clog2(QUO_W + 1);

   logic [DEN_W-1:0] rem_q;
   logic [DEN_W-1:0] den_q;
   logic [QUO_W-1:0] quo_q;
   logic [CNT_W-1:0] cnt_q;

   logic [DEN_W-1:0] rem_in_c;
   logic [QUO_W-1:0] quo_in_c;
   logic [DEN_W-1:0] den_in_c;
   logic [DEN_W:0]   trial_c;
   logic [DEN_W-1:0] rem_out_c;
   logic [QUO_W-1:0] quo_out_c;

   // One restoring step; the quotient register doubles as the dividend shifter.
   always_comb begin
      rem_in_c  = rem_q;
      quo_in_c  = quo_q;
      den_in_c  = den_q;
      if (start) begin
         rem_in_c = dividend[DVD_W-1:QUO_W];
         quo_in_c = dividend[QUO_W-1:0];
         den_in_c = divisor;
      end
      trial_c   = {rem_in_c, quo_in_c[QUO_W-1]};
      rem_out_c = DEN_W'(trial_c);
      quo_out_c = QUO_W'({quo_in_c, 1'b0});
      if (trial_c >= {1'b0, den_in_c}) begin
         rem_out_c = DEN_W'(trial_c - {1'b0, den_in_c});
         quo_out_c = QUO_W'({quo_in_c, 1'b1});
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rem_q <= '0;
         den_q <= '0;
         quo_q <= '0;
         cnt_q <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            rem_q <= rem_out_c;
            quo_q <= quo_out_c;
            den_q <= den_in_c;
            cnt_q <= CNT_W'(1);
            if (QUO_W == 1) done <= 1'b1;
            else            busy <= 1'b1;
         end else if (busy) begin
            rem_q <= rem_out_c;
            quo_q <= quo_out_c;
            cnt_q <= CNT_W'(cnt_q + 1'b1);
            if (cnt_q == CNT_W'(QUO_W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

   assign quotient = quo_q;

endmodule

// File: rtl/attr_interpolator.sv
// Barycentric interpolator for NUM_ATTR attributes per fragment with one shared
// sequential divider. ATTR_INTERP_ROUND_EN selects round-half-up over truncation.
module attr_interpolator
   import interp_pkg::*;
#(
   parameter int unsigned COORD_W  = 10,
   parameter int unsigned ATTR_W   = 16,
   parameter int unsigned NUM_ATTR = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   attr_interpolator_if.slave   bus
);
   localparam int unsigned WGT_W = wgt_width(COORD_W);
   localparam int unsigned DIF_W = COORD_W + 1;
   localparam int unsigned NUM_W = WGT_W + ATTR_W + 2;
   localparam int unsigned DEN_W = WGT_W - 1;
   localparam int unsigned DVD_W = DEN_W + ATTR_W;
   localparam int unsigned VEC_W = NUM_ATTR * ATTR_W;
   localparam int unsigned CH_W  = (NUM_ATTR > 1) ? $clog2(NUM_ATTR) : 1;

   state_t                  state_q, state_d;
   logic                    in_ready_q, in_ready_d;
   logic                    out_valid_q, out_valid_d;
   logic                    capture_c, load_out_c, div_start_c, ch_last_c;

   logic [COORD_W-1:0]      fx_q, fy_q, x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
   logic [VEC_W-1:0]        a0_q, a1_q, a2_q, res_q;
   logic signed [WGT_W-1:0] den_q, w0_q, w1_q, w2_q;
   logic [CH_W-1:0]         ch_q;
   logic [1:0]              clamp_q, clamp_c;

   logic [COORD_W-1:0]      out_fx_q, out_fy_q;
   logic [VEC_W-1:0]        out_attr_q;
   logic                    out_deg_q;

   logic                    div_busy, div_done;
   logic [ATTR_W-1:0]       div_quo;
   logic [ATTR_W-1:0]       slot_val_c;

   // Edge-function weights relative to vertex 2.
   logic signed [DIF_W-1:0]   dy12_c, dx21_c, dy20_c, dx02_c, dxf2_c, dyf2_c;
   logic signed [2*DIF_W-1:0] p0a_c, p0b_c, p1a_c, p1b_c;
   logic signed [WGT_W-1:0]   w0_c, w1_c, w2_c;

   assign dy12_c = $signed({1'b0, y1_q}) - $signed({1'b0, y2_q});
   assign dx21_c = $signed({1'b0, x2_q}) - $signed({1'b0, x1_q});
   assign dy20_c = $signed({1'b0, y2_q}) - $signed({1'b0, y0_q});
   assign dx02_c = $signed({1'b0, x0_q}) - $signed({1'b0, x2_q});
   assign dxf2_c = $signed({1'b0, fx_q}) - $signed({1'b0, x2_q});
   assign dyf2_c = $signed({1'b0, fy_q}) - $signed({1'b0, y2_q});
   assign p0a_c  = dy12_c * dxf2_c;
   assign p0b_c  = dx21_c * dyf2_c;
   assign p1a_c  = dy20_c * dxf2_c;
   assign p1b_c  = dx02_c * dyf2_c;
   assign w0_c   = WGT_W'(p0a_c) + WGT_W'(p0b_c);
   assign w1_c   = WGT_W'(p1a_c) + WGT_W'(p1b_c);
   assign w2_c   = den_q - w0_c - w1_c;

   // Weighted sum for the current channel.
   logic [ATTR_W-1:0]       a0_ch_c, a1_ch_c, a2_ch_c;
   logic signed [NUM_W-1:0] t0_c, t1_c, t2_c, num_c, sat_lim_c;
   logic                    deg_c;

   assign a0_ch_c = a0_q[int'(ch_q) * ATTR_W +: ATTR_W];
   assign a1_ch_c = a1_q[int'(ch_q) * ATTR_W +: ATTR_W];
   assign a2_ch_c = a2_q[int'(ch_q) * ATTR_W +: ATTR_W];
   assign t0_c    = NUM_W'(w0_q) * NUM_W'($signed({1'b0, a0_ch_c}));
   assign t1_c    = NUM_W'(w1_q) * NUM_W'($signed({1'b0, a1_ch_c}));
   assign t2_c    = NUM_W'(w2_q) * NUM_W'($signed({1'b0, a2_ch_c}));
`ifdef ATTR_INTERP_ROUND_EN
   assign num_c   = t0_c + t1_c + t2_c + NUM_W'(den_q >>> 1);
`else
   assign num_c   = t0_c + t1_c + t2_c;
`endif
   assign sat_lim_c = NUM_W'(den_q) << ATTR_W;
   assign deg_c     = den_q[WGT_W-1] || (den_q == '0);

   always_comb begin
      clamp_c = CLAMP_NONE;
      if (deg_c || num_c[NUM_W-1]) clamp_c = CLAMP_ZERO;
      else if (num_c >= sat_lim_c) clamp_c = CLAMP_SAT;
   end

   logic [DVD_W-1:0] div_dividend_c;
   logic [DEN_W-1:0] div_divisor_c;

   // Clamped channels still run the divider so every channel costs the same.
   assign div_dividend_c = DVD_W'(num_c);
   assign div_divisor_c  = DEN_W'(den_q);

   interp_seq_divider #(
      .QUO_W (ATTR_W),
      .DEN_W (DEN_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start_c),
      .dividend (div_dividend_c),
      .divisor  (div_divisor_c),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quo)
   );

   always_comb begin
      slot_val_c = div_quo;
      case (clamp_q)
         CLAMP_ZERO: slot_val_c = '0;
         CLAMP_SAT:  slot_val_c = '1;
         default:    slot_val_c = div_quo;
      endcase
   end

   assign ch_last_c = (ch_q == CH_W'(NUM_ATTR - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
      end
   end

   // OUTPUT spends its first cycle loading the output registers, then holds.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      capture_c   = 1'b0;
      load_out_c  = 1'b0;
      div_start_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               capture_c  = 1'b1;
               in_ready_d = 1'b0;
               state_d    = WEIGHTS;
            end
         end
         WEIGHTS: state_d = ACCUM;
         ACCUM: begin
            if (!div_busy) begin
               div_start_c = 1'b1;
               state_d     = DIVIDE;
            end
         end
         DIVIDE: begin
            if (div_done) state_d = ch_last_c ? OUTPUT : ACCUM;
         end
         OUTPUT: begin
            if (!out_valid_q) begin
               load_out_c  = 1'b1;
               out_valid_d = 1'b1;
            end else if (bus.out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (capture_c) begin
         fx_q  <= bus.frag_x;
         fy_q  <= bus.frag_y;
         x0_q  <= bus.x0;
         y0_q  <= bus.y0;
         x1_q  <= bus.x1;
         y1_q  <= bus.y1;
         x2_q  <= bus.x2;
         y2_q  <= bus.y2;
         a0_q  <= bus.attr0;
         a1_q  <= bus.attr1;
         a2_q  <= bus.attr2;
         den_q <= bus.denom;
      end
      if (state_q == WEIGHTS) begin
         w0_q <= w0_c;
         w1_q <= w1_c;
         w2_q <= w2_c;
         ch_q <= '0;
      end
      if (state_q == ACCUM) clamp_q <= clamp_c;
      if (state_q == DIVIDE && div_done) begin
         res_q[int'(ch_q) * ATTR_W +: ATTR_W] <= slot_val_c;
         if (!ch_last_c) ch_q <= CH_W'(ch_q + 1'b1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_fx_q   <= '0;
         out_fy_q   <= '0;
         out_attr_q <= '0;
         out_deg_q  <= 1'b0;
      end else if (load_out_c) begin
         out_fx_q   <= fx_q;
         out_fy_q   <= fy_q;
         out_attr_q <= res_q;
         out_deg_q  <= deg_c;
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out_frag_x     = out_fx_q;
   assign bus.out_frag_y     = out_fy_q;
   assign bus.out_attr       = out_attr_q;
   assign bus.out_degenerate = out_deg_q;

endmodule
